// File: rtl/baud_pkg.sv
// Shared defaults, minimum divisor and state encoding for the programmable baud generator.
package baud_pkg;

  localparam int DEF_DIV_WIDTH  = 16;
  localparam int DEF_FRAC_WIDTH = 4;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int MIN_DIV        = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } baud_state_e;

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional accumulator: picks each oversample period length as div_int or div_int+1
// so the long-run average equals div_int + div_frac/2^FRAC_WIDTH.
module baud_frac_acc
  import baud_pkg::*;
#(
  parameter int DIV_WIDTH  = DEF_DIV_WIDTH,
  parameter int FRAC_WIDTH = DEF_FRAC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  step,
  input  logic [DIV_WIDTH-1:0]  div_int,
  input  logic [FRAC_WIDTH-1:0] div_frac,
  output logic [DIV_WIDTH:0]    period,
  output logic [DIV_WIDTH:0]    period_base
);

  logic [FRAC_WIDTH-1:0] acc_q, acc_d;
  logic [FRAC_WIDTH:0]   sum;
  logic [DIV_WIDTH-1:0]  div_eff;

  always_comb begin
    sum         = {1'b0, acc_q} + {1'b0, div_frac};
    div_eff     = (div_int < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : div_int;
    period_base = {1'b0, div_eff};
    period      = {1'b0, div_eff} + {{DIV_WIDTH{1'b0}}, sum[FRAC_WIDTH]};
  end

  // Clear wins over step; the carry-out of the step is what lengthens the period.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (step) begin
      acc_d = sum[FRAC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/baud_gen_prog.sv
// Programmable fractional baud generator with oversample, mid-bit and bit-end strobes.
// state   | meaning
// ST_IDLE | counters cleared, no ticks, shadow config copied to active each edge
// ST_RUN  | counting periods, emitting ticks, config swapped at period boundaries
module baud_gen_prog
  import baud_pkg::*;
#(
  parameter int DIV_WIDTH  = DEF_DIV_WIDTH,
  parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DIV_WIDTH-1:0]          div_int,
  input  logic [FRAC_WIDTH-1:0]         div_frac,
  input  logic                          cfg_load,
  input  logic                          rx_sync,
  output logic                          os_tick,
  output logic                          mid_tick,
  output logic                          bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
  output logic                          cfg_pending
);

  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam logic [DIV_WIDTH:0]   P_RST   = (DIV_WIDTH+1)'(MIN_DIV);
  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(MIN_DIV);

  baud_state_e state_q, state_d;
  logic [DIV_WIDTH:0]    cnt_q, cnt_d, p_q, p_d;
  logic [PH_W-1:0]       phase_q, phase_d, phase_inc;
  logic                  os_tick_q, os_tick_d, mid_tick_q, mid_tick_d, bit_tick_q, bit_tick_d;
  logic [DIV_WIDTH-1:0]  act_int_q, act_int_d, sh_int_q, sh_int_d, nx_int;
  logic [FRAC_WIDTH-1:0] act_frac_q, act_frac_d, sh_frac_q, sh_frac_d, nx_frac;
  logic                  pend_q, pend_d;
  logic                  acc_clr, acc_step, apply, wrap, sync_load;
  logic [DIV_WIDTH:0]    period, period_base;

  // Configuration that takes effect at the next period start.
  always_comb begin
    sync_load = cfg_load && rx_sync && en && (state_q == ST_RUN);
    if (sync_load) begin
      nx_int  = div_int;
      nx_frac = div_frac;
    end else if (pend_q) begin
      nx_int  = sh_int_q;
      nx_frac = sh_frac_q;
    end else begin
      nx_int  = act_int_q;
      nx_frac = act_frac_q;
    end
  end

  baud_frac_acc #(
    .DIV_WIDTH  (DIV_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_frac_acc (
    .clk         (clk),
    .rst         (rst),
    .clr         (acc_clr),
    .step        (acc_step),
    .div_int     (nx_int),
    .div_frac    (nx_frac),
    .period      (period),
    .period_base (period_base)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    phase_d    = phase_q;
    os_tick_d  = 1'b0;
    mid_tick_d = 1'b0;
    bit_tick_d = 1'b0;
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    sh_int_d   = sh_int_q;
    sh_frac_d  = sh_frac_q;
    pend_d     = pend_q;
    acc_clr    = 1'b0;
    acc_step   = 1'b0;
    apply      = 1'b0;
    phase_inc  = phase_q + 1'b1;
    wrap       = (cnt_q == p_q - 1'b1);

    unique case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        phase_d = '0;
        apply   = 1'b1;
        if (en) begin
          state_d  = ST_RUN;
          acc_step = 1'b1;
          p_d      = period;
        end else begin
          acc_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          phase_d = '0;
          acc_clr = 1'b1;
        end else if (rx_sync) begin
          // Phase restart: fresh period with no fractional carry, any due tick dropped.
          cnt_d   = '0;
          phase_d = '0;
          acc_clr = 1'b1;
          p_d     = period_base;
          apply   = 1'b1;
        end else if (wrap) begin
          cnt_d      = '0;
          acc_step   = 1'b1;
          p_d        = period;
          apply      = 1'b1;
          phase_d    = phase_inc;
          os_tick_d  = 1'b1;
          mid_tick_d = (phase_inc == PH_W'(OVERSAMPLE / 2));
          bit_tick_d = (phase_inc == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (apply) begin
      act_int_d  = nx_int;
      act_frac_d = nx_frac;
      pend_d     = 1'b0;
    end
    if (cfg_load) begin
      sh_int_d  = div_int;
      sh_frac_d = div_frac;
      pend_d    = !sync_load;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      p_q        <= P_RST;
      phase_q    <= '0;
      os_tick_q  <= 1'b0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
      act_int_q  <= DIV_RST;
      act_frac_q <= '0;
      sh_int_q   <= DIV_RST;
      sh_frac_q  <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      phase_q    <= phase_d;
      os_tick_q  <= os_tick_d;
      mid_tick_q <= mid_tick_d;
      bit_tick_q <= bit_tick_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      pend_q     <= pend_d;
    end
  end

  assign os_tick     = os_tick_q;
  assign mid_tick    = mid_tick_q;
  assign bit_tick    = bit_tick_q;
  assign os_phase    = phase_q;
  assign cfg_pending = pend_q;

endmodule

// File: tb/tb_baud_gen_prog.sv
// Directed bench for baud_gen_prog: one instance at OVERSAMPLE=4, one at the default 16.
module tb_baud_gen_prog;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cfg_load = 1'b0;
  logic        rx_sync = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;

  logic       os4, mid4, bit4, pend4;
  logic [1:0] ph4;
  logic       os16, mid16, bit16, pend16;
  logic [3:0] ph16;

  int n_chk = 0;
  int n_pass = 0;
  int n_os;

  always #5 clk = ~clk;

  baud_gen_prog #(.OVERSAMPLE(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .div_int(div_int), .div_frac(div_frac),
    .cfg_load(cfg_load), .rx_sync(rx_sync), .os_tick(os4), .mid_tick(mid4),
    .bit_tick(bit4), .os_phase(ph4), .cfg_pending(pend4)
  );

  baud_gen_prog dut16 (
    .clk(clk), .rst(rst), .en(en), .div_int(div_int), .div_frac(div_frac),
    .cfg_load(cfg_load), .rx_sync(rx_sync), .os_tick(os16), .mid_tick(mid16),
    .bit_tick(bit16), .os_phase(ph16), .cfg_pending(pend16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stop, load a divisor while idle, let it settle, then start; returns just after the start edge.
  task automatic restart(input int d, input int f);
    en = 1'b0;
    step();
    div_int  = d[15:0];
    div_frac = f[3:0];
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    step();
    en = 1'b1;
    step();
  endtask

  initial begin
    step();
    step();
    chk("rst_os", os16, 0);
    chk("rst_mid", mid16, 0);
    chk("rst_bit", bit16, 0);
    chk("rst_phase", ph16, 0);
    chk("rst_pend", pend16, 0);
    chk("rst_os4_pend4", {os4, pend4}, 0);
    rst = 1'b0;
    step();
    step();
    chk("release_no_tick", os16, 0);

    div_int  = 16'd4;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    chk("idle_pend_set", pend16, 1);
    step();
    chk("idle_pend_clr", pend16, 0);

    en = 1'b1;
    step();
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("os4_every4", os4, (k % 4 == 0));
      chk("bit4_every16", bit4, (k % 16 == 0));
      chk("mid4_after8", mid4, (k % 16 == 8));
      chk("phase4", ph4, (k / 4) % 4);
      chk("os16_every4", os16, (k % 4 == 0));
      chk("mid16", mid16, (k == 32));
    end

    restart(4, 8);
    n_os = 0;
    for (int k = 1; k <= 900; k++) begin
      step();
      if (os16) n_os++;
      if (k <= 18) chk("frac_pattern", os16, (k % 9 == 0) || (k % 9 == 4));
    end
    chk("frac_count_900", n_os, 200);

    restart(4, 0);
    for (int k = 1; k <= 18; k++) begin
      step();
      chk("load_os", os16, (k == 4) || (k == 8) || (k == 18));
      chk("load_pend", pend16, (k == 6) || (k == 7));
      if (k == 5) begin
        div_int  = 16'd10;
        cfg_load = 1'b1;
      end
      if (k == 6) cfg_load = 1'b0;
    end

    restart(4, 0);
    for (int k = 1; k <= 60; k++) begin
      step();
      if (k < 24) begin
        chk("sync_pre_os", os16, (k % 4 == 0));
        chk("sync_pre_phase", ph16, k / 4);
      end else begin
        chk("sync_os", os16, (k > 24) && ((k - 24) % 4 == 0));
        chk("sync_phase", ph16, (k - 24) / 4);
      end
      chk("sync_mid", mid16, (k == 56));
      chk("sync_bit", bit16, 0);
      if (k == 23) rx_sync = 1'b1;
      if (k == 24) rx_sync = 1'b0;
    end

    restart(4, 0);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("en_drop_os", os16, (k == 4) || (k == 15));
      chk("en_drop_phase", ph16, ((k >= 4 && k <= 6) || k >= 15) ? 1 : 0);
      if (k == 6) en = 1'b0;
      if (k == 10) en = 1'b1;
    end

    restart(0, 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("div0_period2", os16, (k % 2 == 0));
    end
    restart(1, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("div1_period2", os16, (k % 2 == 0));
    end
    div_int  = 16'd7;
    cfg_load = 1'b1;
    step();
    chk("pre_rst_os", os16, 1);
    chk("pre_rst_pend", pend16, 1);
    cfg_load = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_os", os16, 0);
    chk("async_rst_phase", ph16, 0);
    chk("async_rst_pend", pend16, 0);
    chk("async_rst_os4_phase4", {os4, ph4}, 0);
    en = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_release_no_tick", os16, 0);
    en = 1'b1;
    step();
    step();
    chk("rst_div_k1", os16, 0);
    step();
    chk("rst_div_k2", os16, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
